// File: rtl/register_bank_pkg.sv
// Shared constants and types for the decode-stage register file and its clients.
package register_bank_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;

  localparam reg_addr_t ZERO_REG_ADDR = '0;

endpackage

// File: rtl/register_bank_if.sv
// Decode read ports plus the write-back bus; master drives addresses/write-back, slave is the bank.
interface register_bank_if;
  import register_bank_pkg::*;

  logic      rd_ena;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  reg_data_t rd_data_a;
  reg_data_t rd_data_b;
  logic      wb_reg_wr_ena;
  reg_addr_t wb_reg_addr;
  reg_data_t wb_reg_data;

  modport master (
    output rd_ena, rd_addr_a, rd_addr_b, wb_reg_wr_ena, wb_reg_addr, wb_reg_data,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  rd_ena, rd_addr_a, rd_addr_b, wb_reg_wr_ena, wb_reg_addr, wb_reg_data,
    output rd_data_a, rd_data_b
  );

endinterface

// File: rtl/register_bank_read_port.sv
// One registered read port: stall hold, zero-register forcing and optional write-through bypass.
// Bypass is built only when REG_BANK_BYPASS_EN is defined.
module register_bank_read_port
  import register_bank_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rd_ena_i,
  input  reg_addr_t rd_addr_i,
  input  reg_data_t arr_word_i,
  input  logic      wb_wr_ena_i,
  input  reg_addr_t wb_addr_i,
  input  reg_data_t wb_data_i,
  output reg_data_t rd_data_o
);

  reg_data_t rd_data_q;
  reg_data_t rd_data_d;
  reg_data_t word_c;

`ifdef REG_BANK_BYPASS_EN
  // Forward the in-flight write-back word so decode never sees a stale value.
  always_comb begin
    word_c = arr_word_i;
    if (wb_wr_ena_i && (wb_addr_i == rd_addr_i)) begin
      word_c = wb_data_i;
    end
  end
`else
  logic unused_wb_c;
  assign unused_wb_c = ^{wb_wr_ena_i, wb_addr_i, wb_data_i};
  assign word_c      = arr_word_i;
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_ena_i) begin
      rd_data_d = (rd_addr_i == ZERO_REG_ADDR) ? '0 : word_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/register_bank.sv
// 32 x 32-bit general-purpose register file with two registered read ports and one write-back port.
// Optional write-through bypass: define REG_BANK_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  register_bank_if.slave bus
);

  reg_data_t regs_q [NUM_REGS];
  logic      wr_en_c;

  // Register 0 is never written, so it stays at its reset value of zero.
  assign wr_en_c = bus.wb_reg_wr_ena && (bus.wb_reg_addr != ZERO_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[bus.wb_reg_addr] <= bus.wb_reg_data;
    end
  end

  register_bank_read_port u_port_a (
    .clk         (clk),
    .rst         (rst),
    .rd_ena_i    (bus.rd_ena),
    .rd_addr_i   (bus.rd_addr_a),
    .arr_word_i  (regs_q[bus.rd_addr_a]),
    .wb_wr_ena_i (bus.wb_reg_wr_ena),
    .wb_addr_i   (bus.wb_reg_addr),
    .wb_data_i   (bus.wb_reg_data),
    .rd_data_o   (bus.rd_data_a)
  );

  register_bank_read_port u_port_b (
    .clk         (clk),
    .rst         (rst),
    .rd_ena_i    (bus.rd_ena),
    .rd_addr_i   (bus.rd_addr_b),
    .arr_word_i  (regs_q[bus.rd_addr_b]),
    .wb_wr_ena_i (bus.wb_reg_wr_ena),
    .wb_addr_i   (bus.wb_reg_addr),
    .wb_data_i   (bus.wb_reg_data),
    .rd_data_o   (bus.rd_data_b)
  );

endmodule
